// File: rtl/fixed_sdiv_arbiter.sv
// Round-robin front end for one shared, fully pipelined signed fixed-point divider.
// A tag pipeline travels alongside the divider and steers each quotient back to its requester.
module fixed_sdiv_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_WIDTH  = 16,
  parameter int DIV_LATENCY = 26,
  parameter int ID_W        = $clog2(N_REQ)
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]      req_numer,
  input  logic [N_REQ*DATA_WIDTH-1:0]      req_denom,
  input  logic                             flush_req,
  output logic                             flush_done,
  output logic [DATA_WIDTH-1:0]            div_numer,
  output logic [DATA_WIDTH-1:0]            div_denom,
  output logic                             div_src_en,
  input  logic [DATA_WIDTH-1:0]            div_quotient,
  input  logic                             div_dst_en,
  output logic [N_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_dz,
  output logic [$clog2(DIV_LATENCY+2)-1:0] inflight,
  output logic                             err_desync
);

  localparam int CNT_W = $clog2(DIV_LATENCY + 2);
  localparam logic [CNT_W-1:0]      MASK_INIT = CNT_W'(DIV_LATENCY + 1);
  localparam logic [DATA_WIDTH-1:0] SAT_POS   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_NEG   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  if (N_REQ < 2 || N_REQ > 8 || FRAC_WIDTH >= DATA_WIDTH) begin : g_param_err
    $error("fixed_sdiv_arbiter: unsupported parameter combination");
  end

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FLUSHED} state_t;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
    logic            dz;
    logic            sgn;
    logic            nz;
  } tag_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]      mask_cnt_q, mask_cnt_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] div_numer_q, div_numer_d;
  logic [DATA_WIDTH-1:0] div_denom_q, div_denom_d;
  logic                  div_src_en_q, div_src_en_d;
  tag_t                  issue_tag_q, issue_tag_d;
  tag_t                  tag_pipe_q [DIV_LATENCY];
  tag_t                  tag_pipe_d [DIV_LATENCY];
  logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_dz_q, rsp_dz_d;
  logic                  flush_done_q, flush_done_d;
  logic                  err_desync_q, err_desync_d;

  logic [N_REQ-1:0]      grant;
  logic [ID_W-1:0]       grant_id, scan_id;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] numer_sel, denom_sel;
  logic                  mask_done, deliver;
  tag_t                  tail;

  assign mask_done = (mask_cnt_q == '0);
  assign tail      = tag_pipe_q[DIV_LATENCY-1];
  assign deliver   = div_dst_en && tail.v && mask_done;

  // Grants are also withheld in the very cycle flush_req rises.
  always_comb begin
    grant    = '0;
    grant_id = ptr_q;
    scan_id  = '0;
    xfer     = 1'b0;
    if (state_q == ST_RUN && mask_done && !flush_req) begin
      for (int unsigned i = 1; i <= N_REQ; i++) begin
        scan_id = ID_W'((32'(ptr_q) + i) % N_REQ);
        if (!xfer && req_valid[scan_id]) begin
          xfer     = 1'b1;
          grant_id = scan_id;
        end
      end
    end
    if (xfer) grant[grant_id] = 1'b1;
  end

  assign numer_sel = req_numer[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign denom_sel = req_denom[grant_id*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    ptr_d        = xfer ? grant_id : ptr_q;
    mask_cnt_d   = mask_done ? '0 : mask_cnt_q - 1'b1;
    div_numer_d  = xfer ? numer_sel : div_numer_q;
    div_denom_d  = xfer ? denom_sel : div_denom_q;
    div_src_en_d = xfer;

    issue_tag_d = '0;
    if (xfer) begin
      issue_tag_d.v   = 1'b1;
      issue_tag_d.id  = grant_id;
      issue_tag_d.dz  = (denom_sel == '0);
      issue_tag_d.sgn = numer_sel[DATA_WIDTH-1];
      issue_tag_d.nz  = |numer_sel;
    end

    // Extra issue register stage lines the tag tail up with div_dst_en.
    tag_pipe_d[0] = issue_tag_q;
    for (int unsigned i = 1; i < DIV_LATENCY; i++) tag_pipe_d[i] = tag_pipe_q[i-1];

    inflight_d   = inflight_q + CNT_W'(xfer) - CNT_W'(tail.v);
    err_desync_d = err_desync_q | (mask_done && (div_dst_en != tail.v));

    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_dz_d    = 1'b0;
    if (deliver) begin
      rsp_valid_d[tail.id] = 1'b1;
      rsp_dz_d             = tail.dz;
      if (tail.dz) rsp_data_d = tail.nz ? (tail.sgn ? SAT_NEG : SAT_POS) : '0;
      else         rsp_data_d = div_quotient;
    end

    state_d = state_q;
    unique case (state_q)
      ST_RUN:     if (flush_req) state_d = ST_DRAIN;
      ST_DRAIN:   if (!flush_req) state_d = ST_RUN;
                  else if (inflight_q == '0) state_d = ST_FLUSHED;
      ST_FLUSHED: if (!flush_req) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
    flush_done_d = (state_d == ST_FLUSHED);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_RUN;
      ptr_q        <= ID_W'(N_REQ - 1);
      mask_cnt_q   <= MASK_INIT;
      inflight_q   <= '0;
      div_numer_q  <= '0;
      div_denom_q  <= '0;
      div_src_en_q <= 1'b0;
      issue_tag_q  <= '0;
      for (int unsigned i = 0; i < DIV_LATENCY; i++) tag_pipe_q[i] <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_dz_q     <= 1'b0;
      flush_done_q <= 1'b0;
      err_desync_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      mask_cnt_q   <= mask_cnt_d;
      inflight_q   <= inflight_d;
      div_numer_q  <= div_numer_d;
      div_denom_q  <= div_denom_d;
      div_src_en_q <= div_src_en_d;
      issue_tag_q  <= issue_tag_d;
      for (int unsigned i = 0; i < DIV_LATENCY; i++) tag_pipe_q[i] <= tag_pipe_d[i];
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_dz_q     <= rsp_dz_d;
      flush_done_q <= flush_done_d;
      err_desync_q <= err_desync_d;
    end
  end

  assign req_ready  = grant;
  assign div_numer  = div_numer_q;
  assign div_denom  = div_denom_q;
  assign div_src_en = div_src_en_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_dz     = rsp_dz_q;
  assign inflight   = inflight_q;
  assign flush_done = flush_done_q;
  assign err_desync = err_desync_q;

endmodule
